// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store adapter between the RV32I memory stage and a
// word-wide data memory with a single whole-word write enable.
//  - Loads are zero-latency: lane select plus sign/zero extension of mem_rd.
//  - SW writes straight through in the request cycle.
//  - SB/SH run a two-cycle read-modify-write: the IDLE cycle reads the word
//    and stalls, and the WRITE cycle writes the merged word back.
//  - Illegal funct3 codes and misaligned accesses raise err, write nothing
//    and do not stall.
module mem_access_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   input  logic                  req_write,
   input  logic [2:0]            funct3,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  stall,
   output logic                  err,
   output logic [ADDR_WIDTH-1:0] mem_a,
   output logic [DATA_WIDTH-1:0] mem_wd,
   output logic                  mem_we,
   input  logic [DATA_WIDTH-1:0] mem_rd
);

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic {
      IDLE  = 1'b0,
      WRITE = 1'b1
   } state_t;

   state_t                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   merge_q, merge_d;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [ADDR_WIDTH-1:0]   word_idx;

   logic                    is_b, is_h, is_w, is_bu, is_hu;
   logic                    legal_code, misaligned, bad_access;
   logic [7:0]              byte_lane;
   logic [15:0]             half_lane;
   logic [DATA_WIDTH-1:0]   load_ext;
   logic                    we_raw;

   assign word_idx = {2'b00, addr[ADDR_WIDTH-1:2]};

   // Decode funct3 into access width and classify illegal/misaligned requests.
   always_comb begin
      is_b       = (funct3 == F3_B);
      is_h       = (funct3 == F3_H);
      is_w       = (funct3 == F3_W);
      is_bu      = (funct3 == F3_BU);
      is_hu      = (funct3 == F3_HU);
      // BU/HU exist only as loads.
      legal_code = is_b | is_h | is_w | ((is_bu | is_hu) & ~req_write);
      misaligned = ((is_h | is_hu) & addr[0]) | (is_w & (addr[1:0] != 2'b00));
      bad_access = ~legal_code | misaligned;
   end

   // Select the addressed byte/half lane and extend it to a full word.
   always_comb begin
      // NOTE: every variable assigned in an always_comb gets a value on every
      // path (defaults first), otherwise synthesis infers a latch.
      byte_lane = mem_rd[7:0];
      case (addr[1:0])
         2'd0: byte_lane = mem_rd[7:0];
         2'd1: byte_lane = mem_rd[15:8];
         2'd2: byte_lane = mem_rd[23:16];
         2'd3: byte_lane = mem_rd[31:24];
         default: byte_lane = mem_rd[7:0];
      endcase
      half_lane = addr[1] ? mem_rd[31:16] : mem_rd[15:0];

      load_ext = mem_rd;
      if (is_b)       load_ext = {{(DATA_WIDTH-8){byte_lane[7]}}, byte_lane};
      else if (is_bu) load_ext = {{(DATA_WIDTH-8){1'b0}}, byte_lane};
      else if (is_h)  load_ext = {{(DATA_WIDTH-16){half_lane[15]}}, half_lane};
      else if (is_hu) load_ext = {{(DATA_WIDTH-16){1'b0}}, half_lane};
   end

   // Build the merged word for SB/SH: current memory word with the store lane(s) replaced.
   always_comb begin
      merge_d = mem_rd;
      if (is_b) begin
         case (addr[1:0])
            2'd0: merge_d[7:0]   = wdata[7:0];
            2'd1: merge_d[15:8]  = wdata[7:0];
            2'd2: merge_d[23:16] = wdata[7:0];
            2'd3: merge_d[31:24] = wdata[7:0];
            default: merge_d = mem_rd;
         endcase
      end else if (is_h) begin
         if (addr[1]) merge_d[31:16] = wdata[15:0];
         else         merge_d[15:0]  = wdata[15:0];
      end
   end

   // Next-state and output logic of the sub-word store FSM.
   always_comb begin
      state_d = state_q;
      rdata   = '0;
      stall   = 1'b0;
      err     = 1'b0;
      we_raw  = 1'b0;
      mem_wd  = wdata;
      mem_a   = word_idx;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (bad_access) begin
                  err = 1'b1;
               end else if (!req_write) begin
                  rdata = load_ext;
               end else if (is_w) begin
                  we_raw = 1'b1;
               end else begin
                  // SB/SH: read this cycle, write the merged word next cycle.
                  stall   = 1'b1;
                  state_d = WRITE;
               end
            end
         end
         WRITE: begin
            // The held request is ignored; only the captured RMW is written.
            mem_a   = addr_q;
            mem_wd  = merge_q;
            we_raw  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Reset blocks any memory write in the same cycle, including mid-RMW.
   assign mem_we = we_raw & ~rst;

   // State register plus RMW capture registers.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (rst) begin
         state_q <= IDLE;
         merge_q <= '0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && state_d == WRITE) begin
            addr_q  <= word_idx;
            merge_q <= merge_d;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed vectors for mem_access_unit with a small
// word memory model. The stimulus pushes the expected per-cycle outputs into
// a queue; a negedge monitor pops and compares them.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_write = 1'b0;
   logic [2:0]  funct3 = 3'b000;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        stall;
   logic        err;
   logic [31:0] mem_a;
   logic [31:0] mem_wd;
   logic        mem_we;
   logic [31:0] mem_rd;

   typedef struct {
      string       name;
      logic [31:0] rdata;
      logic        stall;
      logic        err;
      logic        we;
      logic [31:0] a;
      logic [31:0] wd;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad = 0;

   // Word memory model: combinational read, write on the rising edge.
   logic [31:0] mem [16];
   logic        poke_en = 1'b0;
   logic [3:0]  poke_idx = '0;
   logic [31:0] poke_data = '0;

   assign mem_rd = mem[mem_a[3:0]];

   always @(posedge clk) begin
      if (poke_en)      mem[poke_idx] <= poke_data;
      else if (mem_we)  mem[mem_a[3:0]] <= mem_wd;
   end

   always #5 clk = ~clk;

   mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_write (req_write),
      .funct3    (funct3),
      .addr      (addr),
      .wdata     (wdata),
      .rdata     (rdata),
      .stall     (stall),
      .err       (err),
      .mem_a     (mem_a),
      .mem_wd    (mem_wd),
      .mem_we    (mem_we),
      .mem_rd    (mem_rd)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   // Monitor: one expected record per cycle, compared mid-cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check({e.name, ".rdata"}, rdata, e.rdata);
         check({e.name, ".stall"}, {31'd0, stall}, {31'd0, e.stall});
         check({e.name, ".err"},   {31'd0, err},   {31'd0, e.err});
         check({e.name, ".we"},    {31'd0, mem_we}, {31'd0, e.we});
         check({e.name, ".mem_a"}, mem_a, e.a);
         if (e.we) check({e.name, ".mem_wd"}, mem_wd, e.wd);
      end
   end

   // Drive one cycle of inputs and queue the outputs expected in that cycle.
   task automatic step(input logic r, input logic v, input logic w, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] d,
                       input string name, input logic [31:0] e_rdata, input logic e_stall,
                       input logic e_err, input logic e_we, input logic [31:0] e_a,
                       input logic [31:0] e_wd);
      exp_t e;
      @(posedge clk);
      #1;
      rst = r; req_valid = v; req_write = w; funct3 = f; addr = a; wdata = d;
      e.name = name; e.rdata = e_rdata; e.stall = e_stall; e.err = e_err;
      e.we = e_we; e.a = e_a; e.wd = e_wd;
      exp_q.push_back(e);
   endtask

   task automatic idle(input string name);
      step(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, name, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   // Backdoor write into the memory model during an idle cycle.
   task automatic poke(input logic [3:0] idx, input logic [31:0] data);
      poke_en = 1'b1; poke_idx = idx; poke_data = data;
      idle("poke");
      poke_en = 1'b0;
   endtask

   task automatic load(input logic [2:0] f, input logic [31:0] a, input string name,
                       input logic [31:0] e_rdata);
      step(1'b0, 1'b1, 1'b0, f, a, 32'h0, name, e_rdata, 1'b0, 1'b0, 1'b0, {2'b00, a[31:2]}, 32'h0);
   endtask

   // Sub-word store: one stall cycle, then the merged write with the request held.
   task automatic sub_store(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                            input string name, input logic [31:0] e_merged);
      step(1'b0, 1'b1, 1'b1, f, a, d, {name, ".rd"}, 32'h0, 1'b1, 1'b0, 1'b0,
           {2'b00, a[31:2]}, 32'h0);
      step(1'b0, 1'b1, 1'b1, f, a, d, {name, ".wr"}, 32'h0, 1'b0, 1'b0, 1'b1,
           {2'b00, a[31:2]}, e_merged);
   endtask

   initial begin
      // Reset: outputs quiet, mem_a follows addr.
      step(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, "reset0", 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      step(1'b1, 1'b0, 1'b0, 3'b000, 32'h0001_0008, 32'h0, "reset1", 32'h0, 1'b0, 1'b0, 1'b0,
           32'h0000_4002, 32'h0);
      poke(4'd0, 32'h0000_0000);
      poke(4'd1, 32'h8899_AABB);

      // Test 1: sub-word loads with sign/zero extension.
      load(3'b000, 32'h0001_0005, "lb_l1",  32'hFFFF_FFAA);
      load(3'b100, 32'h0001_0005, "lbu_l1", 32'h0000_00AA);
      load(3'b001, 32'h0001_0006, "lh_h1",  32'hFFFF_8899);
      load(3'b101, 32'h0001_0006, "lhu_h1", 32'h0000_8899);
      load(3'b000, 32'h0001_0007, "lb_l3",  32'hFFFF_FF88);
      load(3'b100, 32'h0001_0004, "lbu_l0", 32'h0000_00BB);
      load(3'b001, 32'h0001_0004, "lh_h0",  32'hFFFF_AABB);
      load(3'b010, 32'h0001_0004, "lw",     32'h8899_AABB);

      // Test 2: SB read-modify-write then read back.
      sub_store(3'b000, 32'h0001_0006, 32'h1234_5677, "sb", 32'h8877_AABB);
      load(3'b010, 32'h0001_0004, "lw_after_sb", 32'h8877_AABB);

      // Test 3: SH on the original word, then SW straight through.
      poke(4'd1, 32'h8899_AABB);
      sub_store(3'b001, 32'h0001_0006, 32'h0000_CAFE, "sh", 32'hCAFE_AABB);
      load(3'b010, 32'h0001_0004, "lw_after_sh", 32'hCAFE_AABB);
      step(1'b0, 1'b1, 1'b1, 3'b010, 32'h0001_0004, 32'hDEAD_BEEF, "sw", 32'h0, 1'b0, 1'b0, 1'b1,
           32'h0000_4001, 32'hDEAD_BEEF);
      load(3'b010, 32'h0001_0004, "lw_after_sw", 32'hDEAD_BEEF);

      // Test 4: misaligned and illegal accesses.
      step(1'b0, 1'b1, 1'b0, 3'b010, 32'h0001_0002, 32'h0, "lw_mis", 32'h0, 1'b0, 1'b1, 1'b0,
           32'h0000_4000, 32'h0);
      step(1'b0, 1'b1, 1'b1, 3'b001, 32'h0001_0001, 32'hFFFF_FFFF, "sh_mis", 32'h0, 1'b0, 1'b1, 1'b0,
           32'h0000_4000, 32'h0);
      step(1'b0, 1'b1, 1'b1, 3'b100, 32'h0001_0004, 32'h1111_1111, "sbu_ill", 32'h0, 1'b0, 1'b1, 1'b0,
           32'h0000_4001, 32'h0);
      step(1'b0, 1'b1, 1'b0, 3'b011, 32'h0001_0004, 32'h0, "ld_ill", 32'h0, 1'b0, 1'b1, 1'b0,
           32'h0000_4001, 32'h0);
      step(1'b0, 1'b1, 1'b0, 3'b101, 32'h0001_0005, 32'h0, "lhu_mis", 32'h0, 1'b0, 1'b1, 1'b0,
           32'h0000_4001, 32'h0);
      load(3'b010, 32'h0001_0000, "lw_w0_intact", 32'h0000_0000);
      load(3'b010, 32'h0001_0004, "lw_w1_intact", 32'hDEAD_BEEF);

      // Test 5: reset during the WRITE cycle suppresses the write.
      poke(4'd1, 32'h8899_AABB);
      step(1'b0, 1'b1, 1'b1, 3'b000, 32'h0001_0006, 32'h1234_5677, "sb_rst.rd", 32'h0, 1'b1, 1'b0,
           1'b0, 32'h0000_4001, 32'h0);
      step(1'b1, 1'b1, 1'b1, 3'b000, 32'h0001_0006, 32'h1234_5677, "sb_rst.wr", 32'h0, 1'b0, 1'b0,
           1'b0, 32'h0000_4001, 32'h0);
      load(3'b000, 32'h0001_0005, "lb_after_rst", 32'hFFFF_FFAA);
      check("mem_w1_after_rst", mem[1], 32'h8899_AABB);

      // Test 6: back-to-back SB, SB, LW to one word.
      sub_store(3'b000, 32'h0001_0004, 32'h0000_0011, "sb_a", 32'h8899_AA11);
      sub_store(3'b000, 32'h0001_0007, 32'h0000_0022, "sb_b", 32'h2299_AA11);
      load(3'b010, 32'h0001_0004, "lw_merged", 32'h2299_AA11);

      idle("tail");
      @(posedge clk);
      @(posedge clk);
      check("queue_drained", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
